systolic_mat_mul: RTL and testbench
===================================

SYSTOLIC_MAT_MUL -- requirements
Module: systolic_mat_mul

Parameters
REQ-001 SHALL provide parameter N, default 4, meaning array dimension (NxN PEs, NxN matrices), legal 2..8.
REQ-002 SHALL provide parameter DATA_W, default 32, meaning operand width.
REQ-003 SHALL provide parameter ACC_W, default 2*DATA_W+clog2(N), meaning accumulator/result width.
REQ-004 SHALL provide parameter SIGNED, default 0, meaning 1 = two's-complement operands, 0 = unsigned.

Interface
REQ-005 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start_i  input  1  one-cycle request to begin a multiply.
REQ-008 SHALL have port accum_i  input  1  sampled with start_i; 1 = C += A*B, 0 = C = A*B.
REQ-009 SHALL have port in_valid_i  input  1  beat valid.
REQ-010 SHALL have port in_ready_o  output  1  block accepts beat.
REQ-011 SHALL have port a_col_i  input  N*DATA_W  column k of A, slice i = A[i][k].
REQ-012 SHALL have port b_row_i  input  N*DATA_W  row k of B, slice j = B[k][j].
REQ-013 SHALL have port out_valid_o  output  1  result row valid.
REQ-014 SHALL have port out_ready_i  input  1  consumer accepts result row.
REQ-015 SHALL have port c_row_o  output  N*ACC_W  result row, slice j = C[r][j].
REQ-016 SHALL have port c_idx_o  output  clog2(N)  index r of row on c_row_o.
REQ-017 SHALL have port busy_o  output  1  high in every state except IDLE.
REQ-018 SHALL have port done_o  output  1  one-cycle pulse after last row accepted.

Function
REQ-019 SHALL implement FSM IDLE -> LOAD -> DRAIN -> OUT -> IDLE.
REQ-020 IDLE: start_i=1 moves to LOAD next cycle; clears all PE accumulators unless accum_i=1; start_i SHALL be ignored in any other state.
REQ-021 LOAD: in_ready_o=1; beat accepted when in_valid_i & in_ready_o; beat counter 0..N-1; after the N-th accepted beat, move to DRAIN.
REQ-022 Input skew: A[i][k] delayed i cycles before entering row i; B[k][j] delayed j cycles before entering column j; internal, no external skewing required.
REQ-023 Cycles in LOAD without an accepted beat SHALL inject zeros into skew stage 0 (gaps legal, result unaffected).
REQ-024 PE(i,j) each cycle: acc += a_in*b_in; passes a right, b down, one register each; product per SIGNED; acc wraps modulo 2^ACC_W.
REQ-025 DRAIN: inject zeros; lasts exactly 2N-1 cycles, then OUT; in_ready_o=0.
REQ-026 OUT: out_valid_o=1, c_row_o = row r (r from 0), c_idx_o=r; r advances only on out_valid_o & out_ready_i; row held stable while out_ready_i=0.
REQ-027 On acceptance of row N-1: done_o=1 for exactly the following cycle, state IDLE in that cycle; accumulators retain C for next accum_i run.
REQ-028 Latency with no gaps and out_ready_i held 1: first row valid N+2N-1+1 cycles after start_i sampled.
REQ-029 in_valid_i outside LOAD SHALL be ignored; no beat consumed.

Reset
REQ-030 rst_i=1 at a rising edge SHALL force IDLE, clear accumulators, skew/PE registers and counters, in any state including mid-LOAD/OUT.
REQ-031 Reset values: in_ready_o=0, out_valid_o=0, done_o=0, busy_o=0, c_row_o=0, c_idx_o=0.
REQ-032 start_i asserted in the same cycle as rst_i SHALL be ignored.

Verification (N=4, DATA_W=32)
REQ-033 A rows {1..4},{5..8},{9..12},{13..16}, B column j all (j+1), no gaps, ready=1 -> rows 10,20,30,40 / 26,52,78,104 / 42,84,126,168 / 58,116,174,232; done_o one pulse.
REQ-034 Same A, B=identity, in_valid_i low 2 cycles between each beat -> C equals A; DRAIN still 7 cycles.
REQ-035 Test REQ-033 then repeat with accum_i=1 -> every result doubled (row0 20,40,60,80).
REQ-036 out_ready_i toggled 0/1 every cycle in OUT -> rows 0..3 delivered in order, each stable while stalled, none dropped or duplicated.
REQ-037 rst_i pulsed after 2 beats in LOAD, then fresh start with REQ-033 data -> REQ-033 results exactly, no residue.
REQ-038 SIGNED=1, A all -3, B all 5 -> every C element = -60 (two's complement in ACC_W).

Source files
------------

// File: rtl/systolic_mat_mul.sv
// Output-stationary NxN systolic multiplier: skewed A columns / B rows stream through a PE grid
// that accumulates C in place; rows are then read out one per out_valid_o/out_ready_i handshake.
module systolic_mat_mul #(
  parameter int N      = 4,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 2*DATA_W + $clog2(N),
  parameter bit SIGNED = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 accum_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [N*DATA_W-1:0]  a_col_i,
  input  logic [N*DATA_W-1:0]  b_row_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [N*ACC_W-1:0]   c_row_o,
  output logic [$clog2(N)-1:0] c_idx_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(2*N);
  localparam int EXT_W = ACC_W - DATA_W;
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(N-1);
  localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(2*N-2);
  localparam logic [IDX_W-1:0] LAST_ROW   = IDX_W'(N-1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] row_q;
  logic             done_q;

  logic beat_acc;
  logic row_acc;
  logic step_en;
  logic run_clr;
  logic acc_clr;

  logic [DATA_W-1:0] a_edge [N];
  logic [DATA_W-1:0] b_edge [N];
  logic [DATA_W-1:0] a_pe   [N][N-1];
  logic [DATA_W-1:0] b_pe   [N-1][N];
  logic [ACC_W-1:0]  acc    [N][N];

  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = LOAD;
      end
      LOAD: begin
        in_ready_o = 1'b1;
        if (in_valid_i && cnt_q == LAST_BEAT) state_d = DRAIN;
      end
      DRAIN: begin
        if (cnt_q == LAST_DRAIN) state_d = OUT;
      end
      OUT: begin
        out_valid_o = 1'b1;
        if (out_ready_i && row_q == LAST_ROW) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign beat_acc = in_valid_i && in_ready_o;
  assign row_acc  = out_valid_o && out_ready_i;
  assign step_en  = (state_q == LOAD) || (state_q == DRAIN);
  assign run_clr  = (state_q == IDLE) && start_i;
  assign acc_clr  = run_clr && !accum_i;

  // cnt_q counts accepted beats in LOAD and elapsed cycles in DRAIN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= row_acc && (row_q == LAST_ROW);
      if (state_q != state_d) begin
        cnt_q <= '0;
      end else if (beat_acc || state_q == DRAIN) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (row_acc) begin
        row_q <= (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
      end
    end
  end

  // Row i of A and column j of B get i / j extra delay stages behind a common stage 0
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [DATA_W-1:0] a_dly [0:i];
    logic [DATA_W-1:0] b_dly [0:i];

    always_ff @(posedge clk_i) begin
      if (rst_i || run_clr) begin
        for (int k = 0; k <= i; k++) begin
          a_dly[k] <= '0;
          b_dly[k] <= '0;
        end
      end else if (step_en) begin
        a_dly[0] <= beat_acc ? a_col_i[i*DATA_W +: DATA_W] : '0;
        b_dly[0] <= beat_acc ? b_row_i[i*DATA_W +: DATA_W] : '0;
        for (int k = 1; k <= i; k++) begin
          a_dly[k] <= a_dly[k-1];
          b_dly[k] <= b_dly[k-1];
        end
      end
    end

    assign a_edge[i] = a_dly[i];
    assign b_edge[i] = b_dly[i];
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DATA_W-1:0] a_in;
      logic [DATA_W-1:0] b_in;
      logic [ACC_W-1:0]  a_ext;
      logic [ACC_W-1:0]  b_ext;
      logic [ACC_W-1:0]  acc_q;

      if (j == 0) begin : g_a_edge
        assign a_in = a_edge[i];
      end else begin : g_a_chain
        assign a_in = a_pe[i][j-1];
      end

      if (i == 0) begin : g_b_edge
        assign b_in = b_edge[j];
      end else begin : g_b_chain
        assign b_in = b_pe[i-1][j];
      end

      // Extending to ACC_W before multiplying gives the exact product modulo 2^ACC_W
      assign a_ext = {{EXT_W{SIGNED && a_in[DATA_W-1]}}, a_in};
      assign b_ext = {{EXT_W{SIGNED && b_in[DATA_W-1]}}, b_in};

      always_ff @(posedge clk_i) begin
        if (rst_i || acc_clr) begin
          acc_q <= '0;
        end else if (step_en) begin
          acc_q <= acc_q + a_ext * b_ext;
        end
      end

      assign acc[i][j] = acc_q;

      if (j < N-1) begin : g_a_fwd
        logic [DATA_W-1:0] a_q;
        always_ff @(posedge clk_i) begin
          if (rst_i || run_clr) begin
            a_q <= '0;
          end else if (step_en) begin
            a_q <= a_in;
          end
        end
        assign a_pe[i][j] = a_q;
      end

      if (i < N-1) begin : g_b_fwd
        logic [DATA_W-1:0] b_q;
        always_ff @(posedge clk_i) begin
          if (rst_i || run_clr) begin
            b_q <= '0;
          end else if (step_en) begin
            b_q <= b_in;
          end
        end
        assign b_pe[i][j] = b_q;
      end
    end
  end

  always_comb begin
    c_row_o = '0;
    if (out_valid_o) begin
      for (int j = 0; j < N; j++) begin
        c_row_o[j*ACC_W +: ACC_W] = acc[row_q][j];
      end
    end
  end

  assign c_idx_o = row_q;
  assign busy_o  = (state_q != IDLE);
  assign done_o  = done_q;

endmodule

// File: tb/tb_systolic_mat_mul.sv
// Bench for systolic_mat_mul: unsigned and signed instances share stimulus; results are
// compared against a plain sum-of-products matrix model kept in the bench.
`timescale 1ns/1ps
module tb_systolic_mat_mul;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 2*DW + $clog2(N);
  localparam int IW = $clog2(N);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i, start_i, accum_i, in_valid_i, out_ready_i;
  logic [N*DW-1:0] a_col_i, b_row_i;

  logic          u_in_ready, u_out_valid, u_busy, u_done;
  logic [N*AW-1:0] u_c_row;
  logic [IW-1:0] u_c_idx;
  logic          s_in_ready, s_out_valid, s_busy, s_done;
  logic [N*AW-1:0] s_c_row;
  logic [IW-1:0] s_c_idx;

  systolic_mat_mul #(.N(N), .DATA_W(DW), .SIGNED(1'b0)) dut_u (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .accum_i(accum_i),
    .in_valid_i(in_valid_i), .in_ready_o(u_in_ready),
    .a_col_i(a_col_i), .b_row_i(b_row_i),
    .out_valid_o(u_out_valid), .out_ready_i(out_ready_i),
    .c_row_o(u_c_row), .c_idx_o(u_c_idx), .busy_o(u_busy), .done_o(u_done)
  );

  systolic_mat_mul #(.N(N), .DATA_W(DW), .SIGNED(1'b1)) dut_s (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .accum_i(accum_i),
    .in_valid_i(in_valid_i), .in_ready_o(s_in_ready),
    .a_col_i(a_col_i), .b_row_i(b_row_i),
    .out_valid_o(s_out_valid), .out_ready_i(out_ready_i),
    .c_row_o(s_c_row), .c_idx_o(s_c_idx), .busy_o(s_busy), .done_o(s_done)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] a_m [N][N];
  logic [DW-1:0] b_m [N][N];
  logic [AW-1:0] exp_u [N][N];
  logic [AW-1:0] exp_s [N][N];
  logic [AW-1:0] res_u [N][N];
  logic [AW-1:0] res_s [N][N];
  logic [IW-1:0] idx_seen [N];
  int first_out, last_beat_t, done_cnt, done_after, stall_viol, timeout, rows_got;
  logic busy_at_done;

  // C = A*B (or C += A*B), computed element by element as a sum of products
  task automatic model_mm(input bit accum);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        logic [AW-1:0] su;
        logic signed [AW-1:0] ss;
        su = accum ? exp_u[i][j] : '0;
        ss = accum ? $signed(exp_s[i][j]) : '0;
        for (int k = 0; k < N; k++) begin
          su = su + AW'(a_m[i][k]) * AW'(b_m[k][j]);
          ss = ss + AW'($signed(a_m[i][k])) * AW'($signed(b_m[k][j]));
        end
        exp_u[i][j] = su;
        exp_s[i][j] = ss;
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        exp_u[i][j] = '0;
        exp_s[i][j] = '0;
      end
  endtask

  task automatic set_spec_data();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        a_m[i][k] = DW'(N*i + k + 1);
        b_m[i][k] = DW'(k + 1);
      end
  endtask

  task automatic set_random_data();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        a_m[i][k] = $urandom;
        b_m[i][k] = $urandom;
      end
  endtask

  function automatic logic [N*DW-1:0] pack_a(input int k);
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = a_m[i][k];
    return v;
  endfunction

  function automatic logic [N*DW-1:0] pack_b(input int k);
    logic [N*DW-1:0] v;
    for (int j = 0; j < N; j++) v[j*DW +: DW] = b_m[k][j];
    return v;
  endfunction

  function automatic logic [N*DW-1:0] rand_vec();
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = $urandom;
    return v;
  endfunction

  // One full multiply; t counts rising edges after the edge that samples start_i.
  // rdy_mode: 0 = ready held 1, 1 = toggle every cycle, 2 = random.
  task automatic do_mm(input bit accum, input int fixed_gap, input bit rnd_gap,
                       input int rdy_mode, input bit noise);
    int t, beat, gap, after;
    bit held;
    logic [N*AW-1:0] held_row;
    logic [IW-1:0] held_idx;
    t = 0; beat = 0; gap = 0; after = 0; held = 1'b0;
    held_row = '0; held_idx = '0;
    first_out = -1; last_beat_t = -1; done_cnt = 0; done_after = -1;
    stall_viol = 0; timeout = 0; busy_at_done = 1'b1; rows_got = 0;
    start_i = 1'b1; accum_i = accum; in_valid_i = 1'b0; out_ready_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    while (after < 4) begin
      if (t > 2000) begin
        timeout = 1;
        break;
      end
      if (u_done) begin
        done_cnt++;
        if (done_after == -1) begin
          done_after   = (rows_got == N) ? after : -2;
          busy_at_done = u_busy;
        end
      end
      if (rows_got == N) after++;

      start_i = (noise && rows_got < N) ? 1'($urandom_range(0, 1)) : 1'b0;
      accum_i = 1'($urandom_range(0, 1));
      if (beat < N) begin
        if (gap == 0) begin
          in_valid_i = 1'b1;
          a_col_i = pack_a(beat);
          b_row_i = pack_b(beat);
          if (u_in_ready) begin
            beat++;
            last_beat_t = t;
            gap = fixed_gap + (rnd_gap ? int'($urandom_range(0, 3)) : 0);
          end
        end else begin
          in_valid_i = 1'b0;
          a_col_i = rand_vec();
          b_row_i = rand_vec();
          gap--;
        end
      end else begin
        in_valid_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        a_col_i = rand_vec();
        b_row_i = rand_vec();
      end

      if (u_out_valid && rows_got < N) begin
        if (first_out < 0) first_out = t;
        if (held && (u_c_row !== held_row || u_c_idx !== held_idx)) stall_viol++;
        case (rdy_mode)
          0:       out_ready_i = 1'b1;
          1:       out_ready_i = (t % 2 == 1);
          default: out_ready_i = 1'($urandom_range(0, 1));
        endcase
        if (out_ready_i) begin
          idx_seen[rows_got] = u_c_idx;
          for (int j = 0; j < N; j++) begin
            res_u[rows_got][j] = u_c_row[j*AW +: AW];
            res_s[rows_got][j] = s_c_row[j*AW +: AW];
          end
          rows_got++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_row = u_c_row;
          held_idx = u_c_idx;
        end
      end else begin
        out_ready_i = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      t++;
    end
    start_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b1; accum_i = 1'b0; in_valid_i = 1'b1; out_ready_i = 1'b1;
    a_col_i = rand_vec(); b_row_i = rand_vec();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (u_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", u_in_ready); end
    checks++; if (u_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", u_out_valid); end
    checks++; if (u_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", u_done); end
    checks++; if (u_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", u_busy); end
    checks++; if (u_c_row !== '0) begin errors++; $display("FAIL reset_c_row got=%0h exp=0", u_c_row); end
    checks++; if (u_c_idx !== '0) begin errors++; $display("FAIL reset_c_idx got=%0d exp=0", u_c_idx); end
    checks++; if ({s_in_ready, s_out_valid, s_done, s_busy} !== 4'b0) begin
      errors++; $display("FAIL reset_signed_flags got=%b exp=0000", {s_in_ready, s_out_valid, s_done, s_busy});
    end
    checks++; if (s_c_row !== '0 || s_c_idx !== '0) begin
      errors++; $display("FAIL reset_signed_row got=%0h/%0d exp=0/0", s_c_row, s_c_idx);
    end
    rst_i = 1'b0; start_i = 1'b0; in_valid_i = 1'b0;
    @(posedge clk); #1;
    checks++; if (u_busy !== 1'b0) begin errors++; $display("FAIL reset_start_ignored busy got=%b exp=0", u_busy); end
    model_clear();
  endtask

  task automatic test_basic();
    set_spec_data();
    model_mm(1'b0);
    do_mm(1'b0, 0, 1'b0, 0, 1'b0);
    checks++; if (timeout != 0) begin errors++; $display("FAIL basic_timeout got=%0d exp=0", timeout); end
    // first row is valid in the 3N-th cycle after start, i.e. after 3N-1 further edges
    checks++; if (first_out != 3*N-1) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", first_out, 3*N-1); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt); end
    checks++; if (done_after != 0) begin errors++; $display("FAIL basic_done_timing got=%0d exp=0", done_after); end
    checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got=%b exp=0", busy_at_done); end
    for (int r = 0; r < N; r++) begin
      checks++; if (idx_seen[r] !== IW'(r)) begin errors++; $display("FAIL basic_idx[%0d] got=%0d exp=%0d", r, idx_seen[r], r); end
      for (int j = 0; j < N; j++) begin
        checks++;
        if (res_u[r][j] !== exp_u[r][j]) begin
          errors++; $display("FAIL basic_c[%0d][%0d] got=%0d exp=%0d", r, j, res_u[r][j], exp_u[r][j]);
        end
      end
    end
  endtask

  task automatic test_accum();
    model_mm(1'b1);
    do_mm(1'b1, 0, 1'b0, 0, 1'b0);
    checks++; if (timeout != 0) begin errors++; $display("FAIL accum_timeout got=%0d exp=0", timeout); end
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) begin
        checks++;
        if (res_u[r][j] !== exp_u[r][j]) begin
          errors++; $display("FAIL accum_c[%0d][%0d] got=%0d exp=%0d", r, j, res_u[r][j], exp_u[r][j]);
        end
      end
  endtask

  task automatic test_gaps();
    set_spec_data();
    for (int k = 0; k < N; k++)
      for (int j = 0; j < N; j++) b_m[k][j] = (k == j) ? DW'(1) : DW'(0);
    model_mm(1'b0);
    do_mm(1'b0, 2, 1'b0, 0, 1'b0);
    checks++; if (timeout != 0) begin errors++; $display("FAIL gaps_timeout got=%0d exp=0", timeout); end
    checks++;
    if (first_out - last_beat_t - 1 != 2*N-1) begin
      errors++; $display("FAIL gaps_drain_len got=%0d exp=%0d", first_out - last_beat_t - 1, 2*N-1);
    end
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) begin
        checks++;
        if (res_u[r][j] !== exp_u[r][j]) begin
          errors++; $display("FAIL gaps_c[%0d][%0d] got=%0d exp=%0d", r, j, res_u[r][j], exp_u[r][j]);
        end
      end
  endtask

  task automatic test_backpressure();
    set_random_data();
    model_mm(1'b0);
    do_mm(1'b0, 0, 1'b0, 1, 1'b0);
    checks++; if (timeout != 0) begin errors++; $display("FAIL bp_timeout got=%0d exp=0", timeout); end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stable got=%0d exp=0", stall_viol); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_count got=%0d exp=1", done_cnt); end
    for (int r = 0; r < N; r++) begin
      checks++; if (idx_seen[r] !== IW'(r)) begin errors++; $display("FAIL bp_idx[%0d] got=%0d exp=%0d", r, idx_seen[r], r); end
      for (int j = 0; j < N; j++) begin
        checks++;
        if (res_u[r][j] !== exp_u[r][j]) begin
          errors++; $display("FAIL bp_c[%0d][%0d] got=%0h exp=%0h", r, j, res_u[r][j], exp_u[r][j]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      bit acc;
      acc = 1'($urandom_range(0, 1));
      set_random_data();
      model_mm(acc);
      do_mm(acc, 0, 1'b1, 2, 1'b1);
      checks++; if (timeout != 0) begin errors++; $display("FAIL rnd%0d_timeout got=%0d exp=0", n, timeout); end
      checks++; if (stall_viol != 0) begin errors++; $display("FAIL rnd%0d_stable got=%0d exp=0", n, stall_viol); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL rnd%0d_done_count got=%0d exp=1", n, done_cnt); end
      for (int r = 0; r < N; r++) begin
        checks++; if (idx_seen[r] !== IW'(r)) begin errors++; $display("FAIL rnd%0d_idx[%0d] got=%0d exp=%0d", n, r, idx_seen[r], r); end
        for (int j = 0; j < N; j++) begin
          checks++;
          if (res_u[r][j] !== exp_u[r][j]) begin
            errors++; $display("FAIL rnd%0d_cu[%0d][%0d] got=%0h exp=%0h", n, r, j, res_u[r][j], exp_u[r][j]);
          end
          checks++;
          if (res_s[r][j] !== exp_s[r][j]) begin
            errors++; $display("FAIL rnd%0d_cs[%0d][%0d] got=%0h exp=%0h", n, r, j, res_s[r][j], exp_s[r][j]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_midload();
    set_random_data();
    start_i = 1'b1; accum_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid_i = 1'b1; a_col_i = pack_a(k); b_row_i = pack_b(k);
      @(posedge clk); #1;
    end
    checks++; if (u_busy !== 1'b1) begin errors++; $display("FAIL midload_busy got=%b exp=1", u_busy); end
    rst_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1;
    checks++; if (u_busy !== 1'b0) begin errors++; $display("FAIL midload_rst_busy got=%b exp=0", u_busy); end
    checks++; if (u_in_ready !== 1'b0) begin errors++; $display("FAIL midload_rst_ready got=%b exp=0", u_in_ready); end
    rst_i = 1'b0; start_i = 1'b0; in_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (u_busy !== 1'b0) begin errors++; $display("FAIL midload_idle busy got=%b exp=0", u_busy); end
    // reset clears the accumulators, so an accumulate run must yield A*B with no residue
    model_clear();
    set_spec_data();
    model_mm(1'b1);
    do_mm(1'b1, 0, 1'b0, 0, 1'b0);
    checks++; if (timeout != 0) begin errors++; $display("FAIL midload_timeout got=%0d exp=0", timeout); end
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) begin
        checks++;
        if (res_u[r][j] !== exp_u[r][j]) begin
          errors++; $display("FAIL midload_c[%0d][%0d] got=%0d exp=%0d", r, j, res_u[r][j], exp_u[r][j]);
        end
      end
  endtask

  task automatic test_signed();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        a_m[i][k] = -DW'(3);
        b_m[i][k] = DW'(5);
      end
    model_mm(1'b0);
    do_mm(1'b0, 0, 1'b0, 0, 1'b0);
    checks++; if (timeout != 0) begin errors++; $display("FAIL signed_timeout got=%0d exp=0", timeout); end
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) begin
        checks++;
        if (res_s[r][j] !== exp_s[r][j]) begin
          errors++; $display("FAIL signed_c[%0d][%0d] got=%0h exp=%0h", r, j, res_s[r][j], exp_s[r][j]);
        end
      end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired got=hang exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; start_i = 1'b0; accum_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    a_col_i = '0; b_row_i = '0;
    test_reset();
    test_basic();
    test_accum();
    test_gaps();
    test_backpressure();
    test_random();
    test_reset_midload();
    test_signed();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
